sisc_clk_rst_ctrl: RTL and testbench

- Synthesizable clock-enable and reset controller for the sisc processor. It generalises the fixed stimulus clock/reset driver into hardware.
- Generates NUM_CH staggered active-low reset releases and a processor clock enable (CE) with run, single-step, divided and freeze modes.
- Also provides a CE cycle counter and a watchdog that halts the core.
- Sits between the board-level clock/reset and the sisc core, plus its memories.

---
 rtl/sisc_ctrl_pkg.sv | 5 +
 rtl/sisc_ce_gen.sv | 36 +++
 rtl/sisc_clk_rst_ctrl.sv | 84 ++++++++
 tb/tb_sisc_clk_rst_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sisc_ctrl_pkg.sv
// sisc_ctrl_pkg: state and clock-enable mode encodings shared by the sisc clock/reset controller
package sisc_ctrl_pkg;
  typedef enum logic [1:0] {ST_RESET = 2'b00, ST_RELEASE = 2'b01, ST_RUN = 2'b10, ST_HALT = 2'b11} state_t;
  typedef enum logic [1:0] {MODE_RUN = 2'b00, MODE_STEP = 2'b01, MODE_DIV = 2'b10, MODE_FREEZE = 2'b11} mode_t;
endpackage

// File: rtl/sisc_ce_gen.sv
// sisc_ce_gen: registered processor clock enable from run/step/divide/freeze modes
module sisc_ce_gen
  import sisc_ctrl_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_en,
  input  logic [1:0]       mode,
  input  logic             step,
  input  logic [DIV_W-1:0] div,
  output logic             ce
);
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [1:0] prev_mode;
  logic armed, fresh;
  // a fresh start (mode change or first enabled cycle) puts the divider at count 0
  always_comb begin
    fresh = !armed || mode != prev_mode;
    div_nxt = (fresh || div_cnt >= div) ? '0 : div_cnt + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst || !run_en) begin
      ce <= 1'b0;
      div_cnt <= '0;
      prev_mode <= MODE_RUN;
      armed <= 1'b0;
    end else begin
      ce <= mode == MODE_RUN ? 1'b1 : mode == MODE_STEP ? step : mode == MODE_DIV ? div_nxt == div : 1'b0;
      div_cnt <= div_nxt;
      prev_mode <= mode;
      armed <= 1'b1;
    end
  end
endmodule

// File: rtl/sisc_clk_rst_ctrl.sv
// sisc_clk_rst_ctrl: staggered reset release, clock-enable modes, CE cycle counter and watchdog for the sisc core
module sisc_clk_rst_ctrl
  import sisc_ctrl_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int STAGGER     = 2,
  parameter int CNT_W       = 32,
  parameter int DIV_W       = 8,
  parameter int WDOG_W      = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SW_RST,
  input  logic [1:0]        MODE,
  input  logic              STEP,
  input  logic [DIV_W-1:0]  DIV,
  input  logic              HALT_IN,
  input  logic              WDOG_KICK,
  input  logic [WDOG_W-1:0] WDOG_LIMIT,
  output logic [NUM_CH-1:0] RST_F_OUT,
  output logic              CE,
  output logic [CNT_W-1:0]  CYCLE_CNT,
  output logic              WDOG_TO,
  output logic [1:0]        STATE
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int REL_LAST = (NUM_CH - 1) * STAGGER;
  localparam int RW = $clog2(REL_LAST + 2);
  state_t state;
  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] rel_cnt;
  logic [WDOG_W-1:0] wd_cnt;
  logic [NUM_CH-1:0] rel_mask;
  logic wd_hit, sw_go, stay_run;
  always_comb begin
    rel_mask = '0;
    for (int i = 0; i < NUM_CH; i++) rel_mask[i] = int'(rel_cnt) + 1 >= i * STAGGER;
  end
  assign wd_hit = state == ST_RUN && WDOG_LIMIT != '0 && CE && !WDOG_KICK &&
                  {1'b0, wd_cnt} + 1'b1 >= {1'b0, WDOG_LIMIT};
  assign sw_go = SW_RST && state != ST_RESET;
  // CE is only produced for edges that leave the controller in RUN, so it drops right after a halt
  assign stay_run = state == ST_RUN && !SW_RST && !HALT_IN && !wd_hit;
  assign STATE = state;
  sisc_ce_gen #(.DIV_W(DIV_W)) u_ce_gen (
    .clk(CLK), .rst(RST), .run_en(stay_run), .mode(MODE), .step(STEP), .div(DIV), .ce(CE)
  );
  always_ff @(posedge CLK) begin
    if (RST || sw_go) begin
      state <= ST_RESET;
      hold_cnt <= '0;
      rel_cnt <= '0;
      wd_cnt <= '0;
      RST_F_OUT <= '0;
      CYCLE_CNT <= '0;
      WDOG_TO <= 1'b0;
    end else begin
      if (CE) CYCLE_CNT <= CYCLE_CNT + 1'b1;
      case (state)
        ST_RESET: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (int'(hold_cnt) == HOLD_CYCLES - 1) begin
            state <= ST_RELEASE;
            rel_cnt <= '0;
            RST_F_OUT <= NUM_CH'(1);
          end
        end
        ST_RELEASE: begin
          rel_cnt <= rel_cnt + 1'b1;
          RST_F_OUT <= rel_mask;
          if (int'(rel_cnt) == REL_LAST) state <= ST_RUN;
        end
        ST_RUN: begin
          if (WDOG_KICK) wd_cnt <= '0;
          else if (CE && WDOG_LIMIT != '0) wd_cnt <= wd_cnt + 1'b1;
          if (wd_hit) WDOG_TO <= 1'b1;
          if (HALT_IN || wd_hit) state <= ST_HALT;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sisc_clk_rst_ctrl.sv
// tb_sisc_clk_rst_ctrl: directed and randomized checks of the sisc clock/reset controller against a timeline model
module tb_sisc_clk_rst_ctrl;
  localparam int NUM_CH = 2, HOLD = 4, STAGGER = 2, CNT_W = 32, DIV_W = 8, WDOG_W = 16;
  localparam int RUN_START = HOLD + (NUM_CH - 1) * STAGGER + 1;
  logic CLK = 0, RST = 1, SW_RST = 0, STEP = 0, HALT_IN = 0, WDOG_KICK = 0;
  logic [1:0] MODE = 0;
  logic [DIV_W-1:0] DIV = 0;
  logic [WDOG_W-1:0] WDOG_LIMIT = 0;
  logic [NUM_CH-1:0] RST_F_OUT;
  logic CE, WDOG_TO;
  logic [CNT_W-1:0] CYCLE_CNT;
  logic [1:0] STATE;
  int checks = 0, failures = 0;
  sisc_clk_rst_ctrl #(
    .NUM_CH(NUM_CH), .HOLD_CYCLES(HOLD), .STAGGER(STAGGER), .CNT_W(CNT_W), .DIV_W(DIV_W), .WDOG_W(WDOG_W)
  ) dut (
    .CLK(CLK), .RST(RST), .SW_RST(SW_RST), .MODE(MODE), .STEP(STEP), .DIV(DIV), .HALT_IN(HALT_IN),
    .WDOG_KICK(WDOG_KICK), .WDOG_LIMIT(WDOG_LIMIT), .RST_F_OUT(RST_F_OUT), .CE(CE),
    .CYCLE_CNT(CYCLE_CNT), .WDOG_TO(WDOG_TO), .STATE(STATE)
  );
  always #5 CLK = ~CLK;
  // timeline model: m_e counts edges since the last accepted reset; everything else follows from it
  int m_e = 0, m_wd = 0, m_phase = 0;
  bit m_halt = 0, m_ce = 0, m_to = 0, m_fresh = 1;
  logic [31:0] m_cnt = 0;
  logic [1:0] m_prev = 0, m_st = 0;
  logic [NUM_CH-1:0] m_rf = 0;
  always @(posedge CLK) begin
    bit run, to, stop;
    run = !m_halt && m_e >= RUN_START;
    if (RST || (SW_RST && m_e >= HOLD)) begin
      m_e = 0; m_halt = 0; m_ce = 0; m_cnt = 0; m_wd = 0; m_to = 0; m_fresh = 1;
    end else begin
      to = run && WDOG_LIMIT != 0 && m_ce && !WDOG_KICK && m_wd + 1 >= int'(WDOG_LIMIT);
      stop = run && (HALT_IN || to);
      if (m_ce) m_cnt = m_cnt + 1;
      if (run && WDOG_KICK) m_wd = 0;
      else if (run && m_ce && WDOG_LIMIT != 0) m_wd++;
      if (to) m_to = 1;
      if (run && !stop) begin
        m_phase = (m_fresh || MODE != m_prev) ? 0 : m_phase + 1;
        m_ce = MODE == 0 ? 1'b1 : MODE == 1 ? STEP : MODE == 2 ? (m_phase % (int'(DIV) + 1) == int'(DIV)) : 1'b0;
        m_prev = MODE;
        m_fresh = 0;
      end else begin
        m_ce = 0;
        m_fresh = 1;
      end
      if (stop) m_halt = 1;
      if (m_e < 1000000) m_e++;
    end
    for (int i = 0; i < NUM_CH; i++) m_rf[i] = m_e >= HOLD + i * STAGGER;
    m_st = m_halt ? 2'd3 : m_e >= RUN_START ? 2'd2 : m_e >= HOLD ? 2'd1 : 2'd0;
  end
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic test_reset;
    repeat (3) tick();
    checks++;
    if ({RST_F_OUT, CE, CYCLE_CNT, WDOG_TO, STATE} !== '0) begin
      failures++;
      $display("FAIL reset_hold: got rf=%b ce=%b cnt=%0d to=%b st=%0d want all zero", RST_F_OUT, CE, CYCLE_CNT, WDOG_TO, STATE);
    end
    RST = 0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if ({RST_F_OUT, CE, CYCLE_CNT, WDOG_TO, STATE} !== {m_rf, m_ce, m_cnt, m_to, m_st}) begin
        failures++;
        $display("FAIL reset_seq edge %0d: got %h want %h", k, {RST_F_OUT, CE, CYCLE_CNT, WDOG_TO, STATE}, {m_rf, m_ce, m_cnt, m_to, m_st});
      end
      if (k == 3 || k == 4 || k == 6) begin
        checks++;
        if (RST_F_OUT !== (k == 3 ? 2'b00 : k == 4 ? 2'b01 : 2'b11)) begin
          failures++;
          $display("FAIL release_ch edge %0d: got %b", k, RST_F_OUT);
        end
      end
      if (k == 7) begin
        checks++;
        if (STATE !== 2'd2 || CE !== 1'b0) begin
          failures++;
          $display("FAIL run_entry: got st=%0d ce=%b want st=2 ce=0", STATE, CE);
        end
      end
      if (k == 8) begin
        checks++;
        if (CE !== 1'b1) begin
          failures++;
          $display("FAIL first_ce: got %b want 1", CE);
        end
      end
    end
  endtask
  task automatic test_div;
    int seen = 0;
    MODE = 2; DIV = 3;
    for (int k = 1; k <= 22; k++) begin
      tick();
      if (k <= 20 && CE === 1'b1) seen++;
      checks++;
      if ({CE, CYCLE_CNT, STATE} !== {m_ce, m_cnt, m_st}) begin
        failures++;
        $display("FAIL div edge %0d: ce=%b cnt=%0d st=%0d want ce=%b cnt=%0d st=%0d", k, CE, CYCLE_CNT, STATE, m_ce, m_cnt, m_st);
      end
    end
    checks++;
    if (seen != 5) begin
      failures++;
      $display("FAIL div_rate: got %0d CE cycles want 5", seen);
    end
    MODE = 0;
    tick();
    checks++;
    if (CE !== 1'b1) begin
      failures++;
      $display("FAIL div_to_run: got ce=%b want 1", CE);
    end
  endtask
  task automatic test_step;
    int seen = 0;
    MODE = 1;
    for (int k = 1; k <= 20; k++) begin
      STEP = (k == 10 || k == 11 || k == 15);
      tick();
      if (CE === 1'b1) seen++;
      checks++;
      if (CE !== (k == 10 || k == 11 || k == 15) || CYCLE_CNT !== m_cnt) begin
        failures++;
        $display("FAIL step edge %0d: ce=%b cnt=%0d want cnt=%0d", k, CE, CYCLE_CNT, m_cnt);
      end
    end
    STEP = 0;
    checks++;
    if (seen != 3) begin
      failures++;
      $display("FAIL step_count: got %0d want 3", seen);
    end
  endtask
  task automatic test_wdog;
    int halt_k = 0;
    MODE = 0; WDOG_LIMIT = 5;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (halt_k == 0 && STATE === 2'd3) halt_k = k;
      checks++;
      if ({CE, CYCLE_CNT, WDOG_TO, STATE} !== {m_ce, m_cnt, m_to, m_st}) begin
        failures++;
        $display("FAIL wdog edge %0d: got %h want %h", k, {CE, CYCLE_CNT, WDOG_TO, STATE}, {m_ce, m_cnt, m_to, m_st});
      end
    end
    checks++;
    if (halt_k != 6 || WDOG_TO !== 1'b1 || CE !== 1'b0) begin
      failures++;
      $display("FAIL wdog_timeout: halt at edge %0d to=%b ce=%b want edge 6 to=1 ce=0", halt_k, WDOG_TO, CE);
    end
    SW_RST = 1;
    tick();
    SW_RST = 0;
    for (int k = 1; k <= 40; k++) begin
      WDOG_KICK = (k % 4 == 0);
      tick();
      checks++;
      if (WDOG_TO !== 1'b0 || {CE, CYCLE_CNT, STATE} !== {m_ce, m_cnt, m_st}) begin
        failures++;
        $display("FAIL wdog_kick edge %0d: to=%b ce=%b cnt=%0d st=%0d want to=0 ce=%b cnt=%0d st=%0d", k, WDOG_TO, CE, CYCLE_CNT, STATE, m_ce, m_cnt, m_st);
      end
    end
    WDOG_KICK = 0; WDOG_LIMIT = 0;
    checks++;
    if (STATE !== 2'd2) begin
      failures++;
      $display("FAIL wdog_kick_run: st=%0d want 2", STATE);
    end
  endtask
  task automatic test_halt_swrst;
    HALT_IN = 1;
    tick();
    HALT_IN = 0;
    repeat (2) tick();
    checks++;
    if (STATE !== 2'd3 || CE !== 1'b0 || RST_F_OUT !== 2'b11) begin
      failures++;
      $display("FAIL halt: st=%0d ce=%b rf=%b want st=3 ce=0 rf=11", STATE, CE, RST_F_OUT);
    end
    SW_RST = 1;
    tick();
    SW_RST = 0;
    checks++;
    if (RST_F_OUT !== 2'b00 || CYCLE_CNT !== 0 || STATE !== 2'd0 || CE !== 1'b0) begin
      failures++;
      $display("FAIL sw_rst: rf=%b cnt=%0d st=%0d ce=%b want all zero", RST_F_OUT, CYCLE_CNT, STATE, CE);
    end
    for (int k = 1; k <= 9; k++) begin
      SW_RST = (k == 2);
      tick();
      checks++;
      if ({RST_F_OUT, CE, CYCLE_CNT, WDOG_TO, STATE} !== {m_rf, m_ce, m_cnt, m_to, m_st} ||
          (k == 4 && RST_F_OUT !== 2'b01) || (k == 6 && RST_F_OUT !== 2'b11) || (k == 7 && STATE !== 2'd2)) begin
        failures++;
        $display("FAIL replay edge %0d: got %h want %h", k, {RST_F_OUT, CE, CYCLE_CNT, WDOG_TO, STATE}, {m_rf, m_ce, m_cnt, m_to, m_st});
      end
    end
    SW_RST = 0;
  endtask
  task automatic test_rst_mid_release;
    RST = 1;
    tick();
    RST = 0;
    repeat (5) tick();
    checks++;
    if (RST_F_OUT !== 2'b01 || STATE !== 2'd1) begin
      failures++;
      $display("FAIL mid_release_pre: rf=%b st=%0d want rf=01 st=1", RST_F_OUT, STATE);
    end
    RST = 1;
    tick();
    RST = 0;
    checks++;
    if ({RST_F_OUT, CE, CYCLE_CNT, WDOG_TO, STATE} !== '0 || m_st !== 2'd0) begin
      failures++;
      $display("FAIL mid_release_rst: got %h want 0", {RST_F_OUT, CE, CYCLE_CNT, WDOG_TO, STATE});
    end
  endtask
  task automatic test_random;
    logic [1:0] nm;
    for (int k = 0; k < 600; k++) begin
      nm = $urandom_range(7) == 0 ? 2'($urandom_range(3)) : MODE;
      if (nm != MODE) DIV = DIV_W'($urandom_range(4));
      MODE = nm;
      STEP = $urandom_range(1) == 1;
      HALT_IN = $urandom_range(59) == 0;
      SW_RST = $urandom_range(79) == 0;
      RST = $urandom_range(249) == 0;
      WDOG_KICK = $urandom_range(5) == 0;
      if ($urandom_range(49) == 0) WDOG_LIMIT = WDOG_W'($urandom_range(12));
      tick();
      checks++;
      if ({RST_F_OUT, CE, CYCLE_CNT, WDOG_TO, STATE} !== {m_rf, m_ce, m_cnt, m_to, m_st}) begin
        failures++;
        $display("FAIL random cycle %0d: got %h want %h", k, {RST_F_OUT, CE, CYCLE_CNT, WDOG_TO, STATE}, {m_rf, m_ce, m_cnt, m_to, m_st});
      end
    end
    RST = 0; SW_RST = 0; HALT_IN = 0; WDOG_KICK = 0; STEP = 0;
  endtask
  initial begin
    test_reset();
    test_div();
    test_step();
    test_wdog();
    test_halt_swrst();
    test_rst_mid_release();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
